vmem_region_reader: RTL and testbench

//  Read-back end of the videoMem write path: fetches a rectangular pixel region from

---
 rtl/vmem_region_reader.sv | 196 +++++++++++++++++++
 tb/tb_vmem_region_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_region_reader.sv
// Streams a clipped rectangle of videoMem out in raster order over valid/ready.
// Reads are throttled so that buffered plus in-flight pixels never exceed FIFO_D.
module vmem_region_reader #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int FIFO_D   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  xloc,
  input  logic [8:0]  yloc,
  input  logic [9:0]  xwid,
  input  logic [8:0]  ywid,
  output logic        busy,
  output logic        done,
  output logic [18:0] raddr,
  output logic        re,
  input  logic [8:0]  rdata,
  output logic [8:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last
);

  localparam int CW = $clog2(FIFO_D + 1);
  localparam int PW = $clog2(FIFO_D);
  localparam logic [18:0] W19 = 19'(SCREEN_W);
  localparam logic [18:0] H19 = 19'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_DRAIN, S_DONE} state_t;

  state_t         state_q;
  logic [18:0]    raddr_q;
  logic           re_q;
  logic           re_last_q;
  logic           rvalid_q;
  logic           rd_last_q;
  logic           busy_q;
  logic           done_q;
  logic [9:0]     w_q;
  logic [8:0]     h_q;
  logic [18:0]    step_q;
  logic [9:0]     col_q;
  logic [8:0]     row_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;

  logic [8:0]     fifo_data_q [FIFO_D];
  logic           fifo_last_q [FIFO_D];

  // Region clipping, all at address width so nothing wraps.
  logic [18:0] x19, y19, xw19, yw19, x_rem, y_rem, w_clip, h_clip, base_addr;
  logic        region_ok;

  assign x19       = {9'd0, xloc};
  assign y19       = {10'd0, yloc};
  assign xw19      = {9'd0, xwid};
  assign yw19      = {10'd0, ywid};
  assign x_rem     = (x19 < W19) ? (W19 - x19) : 19'd0;
  assign y_rem     = (y19 < H19) ? (H19 - y19) : 19'd0;
  assign w_clip    = (xw19 < x_rem) ? xw19 : x_rem;
  assign h_clip    = (yw19 < y_rem) ? yw19 : y_rem;
  assign region_ok = (w_clip != 19'd0) && (h_clip != 19'd0);
  assign base_addr = y19 * W19 + x19;

  // Raster position of the read following the one at raddr_q.
  logic        row_end;
  logic [9:0]  nxt_col;
  logic [8:0]  nxt_row;
  logic [18:0] nxt_addr;
  logic        nxt_last;

  assign row_end  = (col_q == w_q - 10'd1);
  assign nxt_col  = row_end ? 10'd0 : col_q + 10'd1;
  assign nxt_row  = row_end ? row_q + 9'd1 : row_q;
  assign nxt_addr = row_end ? raddr_q + step_q : raddr_q + 19'd1;
  assign nxt_last = (nxt_col == w_q - 10'd1) && (nxt_row == h_q - 9'd1);

  // Returning data bypasses an empty buffer so a ready consumer sees it at once.
  logic fifo_empty, push, pop, can_issue, accept;

  assign fifo_empty = (count_q == '0);
  assign push       = rvalid_q && !(fifo_empty && pix_ready);
  assign pop        = !fifo_empty && pix_ready;
  assign pix_valid  = !fifo_empty || rvalid_q;
  assign pix_data   = !fifo_empty ? fifo_data_q[rd_ptr_q] : (rvalid_q ? rdata : 9'd0);
  assign pix_last   = !fifo_empty ? fifo_last_q[rd_ptr_q] : (rvalid_q && rd_last_q);
  assign accept     = pix_valid && pix_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  // Next cycle holds count_d buffered entries plus the read issued now (re_q).
  assign can_issue = (int'(count_d) + int'(re_q)) < FIFO_D;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_D - 1) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rdata;
      fifo_last_q[wr_ptr_q] <= rd_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      raddr_q   <= '0;
      re_q      <= 1'b0;
      re_last_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_last_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      step_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      re_q      <= 1'b0;
      re_last_q <= 1'b0;
      done_q    <= 1'b0;
      rvalid_q  <= re_q;
      rd_last_q <= re_q && re_last_q;
      count_q   <= count_d;
      if (push)
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (region_ok) begin
              w_q       <= w_clip[9:0];
              h_q       <= h_clip[8:0];
              step_q    <= W19 - w_clip + 19'd1;
              raddr_q   <= base_addr;
              re_q      <= 1'b1;
              col_q     <= '0;
              row_q     <= '0;
              re_last_q <= (w_clip == 19'd1) && (h_clip == 19'd1);
              state_q   <= ((w_clip == 19'd1) && (h_clip == 19'd1)) ? S_DRAIN : S_RD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RD: begin
          if (can_issue) begin
            re_q      <= 1'b1;
            raddr_q   <= nxt_addr;
            col_q     <= nxt_col;
            row_q     <= nxt_row;
            re_last_q <= nxt_last;
            if (nxt_last)
              state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (accept && pix_last) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign raddr = raddr_q;
  assign re    = re_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_vmem_region_reader.sv
// Bench for vmem_region_reader: a table of regions plus random regions, each
// compared against a raster-order model of the clipped rectangle and a memory function.
module tb_vmem_region_reader;

  logic        clk;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  xloc  = '0;
  logic [8:0]  yloc  = '0;
  logic [9:0]  xwid  = '0;
  logic [8:0]  ywid  = '0;
  logic        busy, done, re, pix_valid, pix_last, pix_ready;
  logic [18:0] raddr;
  logic [8:0]  rdata = '0;
  logic [8:0]  pix_data;

  vmem_region_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .xloc(xloc), .yloc(yloc), .xwid(xwid), .ywid(ywid),
    .busy(busy), .done(done), .raddr(raddr), .re(re), .rdata(rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] mem_val(input int a);
    int v;
    v = (a * 37) ^ (a >>> 5) ^ 'h15A;
    return v[8:0];
  endfunction

  // videoMem read port: data one cycle after re.
  always @(posedge clk) if (re) rdata <= mem_val(int'(raddr));

  // Consumer: 0 = always ready, 1 = random, 2 = toggle then 10-cycle stall.
  int gcyc = 0, rdy_base = 0, rdy_mode = 0;
  initial begin
    int t;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      gcyc++;
      t = gcyc - rdy_base;
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ($urandom_range(0, 99) < 60);
        default: pix_ready = (t < 10) ? ((t % 2) == 0) : (t < 20) ? 1'b0 : 1'b1;
      endcase
    end
  end

  // Monitor samples on the falling edge.
  logic mon_en = 1'b0, mon_clr = 1'b0;
  int got_addr[$];
  int got_pix[$];
  int got_last[$];
  int cyc, busy_cnt, done_cnt, issued, accepted, max_out, stab_bad, pv_cnt, first_re, first_pv;
  logic hold_v, hold_l;
  logic [8:0] hold_d;

  always @(negedge clk) begin
    if (mon_clr) begin
      got_addr.delete(); got_pix.delete(); got_last.delete();
      cyc = 0; busy_cnt = 0; done_cnt = 0; issued = 0; accepted = 0;
      max_out = 0; stab_bad = 0; pv_cnt = 0; first_re = -1; first_pv = -1;
      hold_v = 1'b0; hold_l = 1'b0; hold_d = '0;
    end else if (mon_en) begin
      cyc++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (re) begin
        got_addr.push_back(int'(raddr));
        issued++;
        if (first_re < 0) first_re = cyc;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (hold_v && !(pix_valid && pix_data == hold_d && pix_last == hold_l)) stab_bad++;
      hold_v = pix_valid && !pix_ready;
      hold_d = pix_data;
      hold_l = pix_last;
      if (pix_valid) begin
        pv_cnt++;
        if (first_pv < 0) first_pv = cyc;
      end
      if (pix_valid && pix_ready) begin
        got_pix.push_back(int'(pix_data));
        got_last.push_back(int'(pix_last));
        accepted++;
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic mon_reset(input int mode);
    @(negedge clk); #1;
    mon_clr  = 1'b1;
    rdy_mode = mode;
    @(negedge clk); #1;
    mon_clr  = 1'b0;
    rdy_base = gcyc;
  endtask

  task automatic run_region(input int x, input int y, input int w, input int h,
                            input int mode, input int restart_at,
                            output int o_n, output int o_first, output int o_busy);
    int ex, ey, n, limit, t;
    int exp_addr[$];
    ex = (x < 640) ? ((w < 640 - x) ? w : 640 - x) : 0;
    ey = (y < 480) ? ((h < 480 - y) ? h : 480 - y) : 0;
    n  = ex * ey;
    for (int r = 0; r < ey; r++)
      for (int c = 0; c < ex; c++)
        exp_addr.push_back((y + r) * 640 + x + c);

    mon_reset(mode);
    @(posedge clk); #1;
    xloc = 10'(x); yloc = 9'(y); xwid = 10'(w); ywid = 9'(h);
    start = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    limit = n * 30 + 60;
    t = 0;
    while (done_cnt == 0 && t < limit) begin
      @(negedge clk); #1;
      t++;
      if (t == restart_at) begin
        xloc = 10'd300; yloc = 9'd200; xwid = 10'd5; ywid = 9'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 mon_en = 1'b0;

    chk("done_pulses", done_cnt, 1);
    chk("busy_end", int'(busy), 0);
    chk("read_count", got_addr.size(), n);
    chk("pixel_count", got_pix.size(), n);
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      if (got_addr[i] != exp_addr[i]) begin
        chk("raddr_seq", got_addr[i], exp_addr[i]);
        break;
      end
    end
    for (int i = 0; i < n && i < got_pix.size(); i++) begin
      if (got_pix[i] != int'(mem_val(exp_addr[i])) || got_last[i] != int'(i == n - 1)) begin
        chk("pix_data", got_pix[i], int'(mem_val(exp_addr[i])));
        chk("pix_last", got_last[i], int'(i == n - 1));
        break;
      end
    end
    if (n > 0) begin
      chk("last_flag_final", got_last.size() > 0 ? got_last[got_last.size() - 1] : 0, 1);
      chk("outstanding_le_2", int'(max_out <= 2), 1);
      chk("stall_stability_violations", stab_bad, 0);
    end else begin
      chk("empty_pix_valid_cycles", pv_cnt, 0);
    end
    if (mode == 0) begin
      chk("busy_cycles", busy_cnt, (n > 0) ? n + 2 : 1);
      if (n > 0) begin
        chk("start_to_re", first_re, 2);
        chk("start_to_valid", first_pv, 3);
      end
    end
    o_n     = got_addr.size();
    o_first = (got_addr.size() > 0) ? got_addr[0] : -1;
    o_busy  = busy_cnt;
    $display("region x=%0d y=%0d w=%0d h=%0d mode=%0d -> reads=%0d pixels=%0d busy=%0d dones=%0d",
             x, y, w, h, mode, got_addr.size(), got_pix.size(), busy_cnt, done_cnt);
  endtask

  typedef struct {
    int x, y, w, h, mode;
    int exp_n, exp_first, exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, first, bsy;
    vecs[0] = '{10,  5,   3, 2, 0, 6, 3210,   8};
    vecs[1] = '{10,  5,   3, 2, 2, 6, 3210,   -1};
    vecs[2] = '{638, 479, 5, 4, 0, 2, 307198, 4};
    vecs[3] = '{10,  5,   0, 2, 0, 0, -1,     1};
    vecs[4] = '{700, 5,   3, 2, 0, 0, -1,     1};
    vecs[5] = '{0,   0,   1, 1, 0, 1, 0,      3};
    vecs[6] = '{5,   470, 4, 20, 1, 40, 300805, -1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_re", int'(re), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_pix_last", int'(pix_last), 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_region(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].mode, -1, n, first, bsy);
      chk("tbl_reads", n, vecs[i].exp_n);
      chk("tbl_first_addr", first, vecs[i].exp_first);
      if (vecs[i].exp_busy >= 0) chk("tbl_busy", bsy, vecs[i].exp_busy);
    end

    // Second start while reading must not disturb the region.
    run_region(20, 30, 8, 3, 1, 6, n, first, bsy);
    chk("restart_first_addr", first, 30 * 640 + 20);

    // Reset in the middle of a read.
    mon_reset(1);
    @(posedge clk); #1;
    xloc = 10'd0; yloc = 9'd0; xwid = 10'd50; ywid = 9'd4;
    start = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrd_started", int'(issued > 0), 1);
    chk("midrd_rst_busy", int'(busy), 0);
    chk("midrd_rst_re", int'(re), 0);
    chk("midrd_rst_raddr", int'(raddr), 0);
    chk("midrd_rst_pix_valid", int'(pix_valid), 0);
    chk("midrd_rst_pix_data", int'(pix_data), 0);
    chk("midrd_rst_pix_last", int'(pix_last), 0);
    chk("midrd_rst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1 mon_en = 1'b0;
    chk("midrd_done_pulses", done_cnt, 0);
    chk("midrd_idle_busy", int'(busy), 0);
    chk("midrd_idle_pix_valid", int'(pix_valid), 0);
    $display("reset mid-read: reads before reset=%0d dones=%0d", issued, done_cnt);

    // Random regions with random backpressure.
    for (int k = 0; k < 10; k++) begin
      run_region(int'($urandom_range(0, 660)), int'($urandom_range(0, 490)),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 6)), 1, -1, n, first, bsy);
    end

    // Full-width band.
    run_region(0, 100, 640, 20, 1, -1, n, first, bsy);
    chk("band_last_addr", (got_addr.size() > 0) ? got_addr[got_addr.size() - 1] : -1, 119 * 640 + 639);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
